// File: rtl/game_pkg.sv
// Shared encodings for the snake game control, drawing and apple blocks.
package game_pkg;

  typedef enum logic [1:0] {
    StStart    = 2'b00,
    StPlay     = 2'b01,
    StGameOver = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    CollNone  = 2'b00,
    CollHit   = 2'b01,
    CollApple = 2'b10
  } collision_e;

  typedef enum logic [2:0] {
    DirIdle  = 3'd0,
    DirUp    = 3'd1,
    DirDown  = 3'd2,
    DirLeft  = 3'd3,
    DirRight = 3'd4
  } direction_e;

  // Score counter increment that sticks at the top value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts frame ticks while enabled and flags the tick that completes a period.
module frame_divider #(
  parameter int unsigned Terminal = 8,
  parameter int unsigned CntW     = $clog2(Terminal) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic tick_i,
  output logic wrap_o
);

  localparam logic [CntW-1:0] Last = CntW'(Terminal - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Combinational so the consumer can react on the same tick.
  assign wrap_o = enable_i & tick_i & (cnt_q == Last);

  // Next count: synchronous clear wins, otherwise count enabled ticks and wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && tick_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_control.sv
// Snake game logic: per-frame collision detection, game FSM, move strobe and score.
module game_control
  import game_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = 640,
  parameter int unsigned V_ACTIVE         = 480,
  parameter int unsigned BORDER           = 10,
  parameter int unsigned BIT              = 10,
  parameter int unsigned FRAMES_PER_STEP  = 8,
  parameter int unsigned GAME_OVER_FRAMES = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  input  logic           video_active,
  input  logic           frame_end,
  input  logic           snake_head_active,
  input  logic           snake_body_active,
  input  logic           apple_active,
  input  logic           start,
  output logic [1:0]     game_state,
  output logic [1:0]     collision,
  output logic           update,
  output logic [7:0]     score
);

  localparam logic [BIT-1:0] WallLo = BIT'(BORDER);
  localparam logic [BIT-1:0] WallXHi = BIT'(H_ACTIVE - BORDER);
  localparam logic [BIT-1:0] WallYHi = BIT'(V_ACTIVE - BORDER);
  localparam int unsigned StepW = $clog2(FRAMES_PER_STEP) + 1;
  localparam int unsigned GoW = $clog2(GAME_OVER_FRAMES) + 1;

  game_state_e state_q, state_d;
  collision_e  collision_q, collision_d;
  logic [7:0]  score_q, score_d;
  logic        update_q, update_d;
  logic        apple_f_q, apple_f_d;
  logic        self_f_q, self_f_d;
  logic        wall_f_q, wall_f_d;

  logic in_play, in_go, sample, at_wall, hit_now;
  logic step_clear, go_clear, step_wrap, go_wrap;

  assign in_play = (state_q == StPlay);
  assign in_go   = (state_q == StGameOver);
  assign sample  = video_active & in_play;
  assign at_wall = (x_pos < WallLo) | (x_pos >= WallXHi) |
                   (y_pos < WallLo) | (y_pos >= WallYHi);
  assign hit_now = self_f_q | wall_f_q;

  assign game_state = state_q;
  assign collision  = collision_q;
  assign update     = update_q;
  assign score      = score_q;

  frame_divider #(
    .Terminal (FRAMES_PER_STEP),
    .CntW     (StepW)
  ) u_step_div (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (step_clear),
    .enable_i (in_play),
    .tick_i   (frame_end),
    .wrap_o   (step_wrap)
  );

  frame_divider #(
    .Terminal (GAME_OVER_FRAMES),
    .CntW     (GoW)
  ) u_go_div (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (go_clear),
    .enable_i (in_go),
    .tick_i   (frame_end),
    .wrap_o   (go_wrap)
  );

  // Game FSM next state; counter clears ride on the transitions that need them.
  always_comb begin
    state_d    = state_q;
    step_clear = 1'b0;
    go_clear   = 1'b0;
    case (state_q)
      StStart: begin
        if (start) begin
          state_d    = StPlay;
          step_clear = 1'b1;
        end
      end
      StPlay: begin
        if (frame_end && hit_now) begin
          state_d  = StGameOver;
          go_clear = 1'b1;
        end
      end
      StGameOver: begin
        if (go_wrap) begin
          state_d = StStart;
        end
      end
      default: state_d = StStart;
    endcase
  end

  // Sticky per-frame flags, frame resolution into collision/score, and the move strobe.
  always_comb begin
    apple_f_d = apple_f_q | (sample & snake_head_active & apple_active);
    self_f_d  = self_f_q  | (sample & snake_head_active & snake_body_active);
    wall_f_d  = wall_f_q  | (sample & snake_head_active & at_wall);
    // A hit on the frame_end cycle itself is dropped; frame_end is outside the visible area.
    if (frame_end) begin
      apple_f_d = 1'b0;
      self_f_d  = 1'b0;
      wall_f_d  = 1'b0;
    end

    collision_d = collision_q;
    if (frame_end) begin
      if (hit_now) begin
        collision_d = CollHit;
      end else if (apple_f_q) begin
        collision_d = CollApple;
      end else begin
        collision_d = CollNone;
      end
    end
    if (state_q == StStart) begin
      collision_d = CollNone;
    end

    score_d = score_q;
    if ((state_q == StStart) && start) begin
      score_d = '0;
    end else if (in_play && frame_end && !hit_now && apple_f_q) begin
      score_d = sat_inc8(score_q);
    end

    // The step count still advances on a hit frame, but no move is issued.
    update_d = step_wrap & ~hit_now;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StStart;
      collision_q <= CollNone;
      score_q     <= '0;
      update_q    <= 1'b0;
      apple_f_q   <= 1'b0;
      self_f_q    <= 1'b0;
      wall_f_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      collision_q <= collision_d;
      score_q     <= score_d;
      update_q    <= update_d;
      apple_f_q   <= apple_f_d;
      self_f_q    <= self_f_d;
      wall_f_q    <= wall_f_d;
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Randomized bench for game_control with a frame-level reference model.
module tb_game_control;

  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int BD  = 10;
  localparam int FPS = 8;
  localparam int GOF = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       video_active = 1'b0;
  logic       frame_end = 1'b0;
  logic       head = 1'b0;
  logic       body = 1'b0;
  logic       apple = 1'b0;
  logic       start = 1'b0;
  logic [1:0] game_state;
  logic [1:0] collision;
  logic       update;
  logic [7:0] score;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: game phase (0 start, 1 play, 3 over) and per-frame pixel tallies.
  int m_state = 0, m_coll = 0, m_upd = 0, m_score = 0;
  int m_play_frames = 0, m_go_frames = 0;
  int n_apple_px = 0, n_self_px = 0, n_wall_px = 0;

  game_control #(
    .H_ACTIVE         (HA),
    .V_ACTIVE         (VA),
    .BORDER           (BD),
    .BIT              (10),
    .FRAMES_PER_STEP  (FPS),
    .GAME_OVER_FRAMES (GOF)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .x_pos             (x_pos),
    .y_pos             (y_pos),
    .video_active      (video_active),
    .frame_end         (frame_end),
    .snake_head_active (head),
    .snake_body_active (body),
    .apple_active      (apple),
    .start             (start),
    .game_state        (game_state),
    .collision         (collision),
    .update            (update),
    .score             (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  prev;
    bit  wall_px;
    prev  = m_state;
    m_upd = 0;
    if (frame_end) begin
      if (prev == 0) begin
        m_coll = 0;
      end else if (prev == 1) begin
        m_play_frames++;
        if (n_self_px > 0 || n_wall_px > 0) begin
          m_coll = 1;
          m_state = 3;
          m_go_frames = 0;
        end else begin
          m_coll = (n_apple_px > 0) ? 2 : 0;
          if (n_apple_px > 0 && m_score < 255) m_score++;
          if (m_play_frames % FPS == 0) m_upd = 1;
        end
      end else begin
        m_coll = 0;
        m_go_frames++;
        if (m_go_frames == GOF) m_state = 0;
      end
      n_apple_px = 0;
      n_self_px  = 0;
      n_wall_px  = 0;
    end else if (prev == 1 && video_active && head) begin
      wall_px = (int'(x_pos) < BD) || (int'(x_pos) >= HA - BD) ||
                (int'(y_pos) < BD) || (int'(y_pos) >= VA - BD);
      if (apple) n_apple_px++;
      if (body) n_self_px++;
      if (wall_px) n_wall_px++;
    end
    if (prev == 0 && start) begin
      m_state = 1;
      m_coll = 0;
      m_score = 0;
      m_play_frames = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_state = 0; m_coll = 0; m_upd = 0; m_score = 0;
        m_play_frames = 0; m_go_frames = 0;
        n_apple_px = 0; n_self_px = 0; n_wall_px = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_state", int'(game_state), m_state);
        check("model_collision", int'(collision), m_coll);
        check("model_update", int'(update), m_upd);
        check("model_score", int'(score), m_score);
      end
    end
  end

  task automatic drive(input bit va, input bit fe, input int x, input int y,
                       input bit h, input bit b, input bit a, input bit st);
    video_active = va;
    frame_end    = fe;
    x_pos        = 10'(x);
    y_pos        = 10'(y);
    head         = h;
    body         = b;
    apple        = a;
    start        = st;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit h, input bit b, input bit a);
    drive(1'b1, 1'b0, x, y, h, b, a, 1'b0);
  endtask

  task automatic fend();
    drive(1'b0, 1'b1, HA, VA - 1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic calm_frame();
    pix(300, 300, 1'b1, 1'b0, 1'b0);
    pix(301, 300, 1'b0, 1'b1, 1'b0);
    fend();
  endtask

  task automatic rand_pixel();
    drive(($urandom % 8) != 0, 1'b0, int'($urandom_range(HA - 1, 0)),
          int'($urandom_range(VA - 1, 0)), ($urandom % 4) == 0, ($urandom % 16) == 0,
          ($urandom % 6) == 0, ($urandom % 2) == 0);
  endtask

  task automatic rand_frame();
    int len;
    len = int'($urandom_range(5, 0));
    for (int i = 0; i < len; i++) rand_pixel();
    drive(($urandom % 4) == 0, 1'b1, int'($urandom_range(HA - 1, 0)),
          int'($urandom_range(VA - 1, 0)), ($urandom % 2) == 0, ($urandom % 2) == 0,
          ($urandom % 2) == 0, ($urandom % 2) == 0);
  endtask

  initial begin
    int frames;
    #2 reset = 1'b1;
    #1;
    check("reset_state", int'(game_state), 0);
    check("reset_collision", int'(collision), 0);
    check("reset_update", int'(update), 0);
    check("reset_score", int'(score), 0);
    #20;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Idle in START: overlaps are ignored.
    pix(5, 5, 1'b1, 1'b1, 1'b1);
    fend();
    check("start_idle_state", int'(game_state), 0);
    check("start_idle_coll", int'(collision), 0);

    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("start_to_play", int'(game_state), 1);
    check("start_score", int'(score), 0);

    for (int f = 1; f <= FPS; f++) begin
      calm_frame();
      check("first_update", int'(update), (f == FPS) ? 1 : 0);
    end
    pix(300, 300, 1'b1, 1'b0, 1'b0);
    check("update_width", int'(update), 0);

    // Apple at (100,100).
    pix(100, 100, 1'b1, 1'b0, 1'b1);
    pix(150, 150, 1'b0, 1'b1, 1'b0);
    fend();
    check("apple_coll", int'(collision), 2);
    check("apple_score", int'(score), 1);
    pix(300, 300, 1'b1, 1'b0, 1'b0);
    pix(310, 300, 1'b0, 1'b0, 1'b1);
    check("apple_hold", int'(collision), 2);
    fend();
    check("apple_release", int'(collision), 0);

    // Head exactly on the inner border edge is not a wall hit.
    pix(BD, 200, 1'b1, 1'b0, 1'b0);
    fend();
    check("border_edge_coll", int'(collision), 0);
    check("border_edge_state", int'(game_state), 1);

    // Reach the 15th frame so the hit lands on a step frame.
    for (int f = 0; f < 4; f++) calm_frame();
    pix(200, 200, 1'b1, 1'b1, 1'b1);
    fend();
    check("self_coll", int'(collision), 1);
    check("self_state", int'(game_state), 3);
    check("self_score", int'(score), 1);
    check("self_no_update", int'(update), 0);

    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("go_ignores_start", int'(game_state), 3);
    check("go_hold_hit", int'(collision), 1);
    for (int i = 1; i <= GOF; i++) begin
      fend();
      if (i == 1) check("go_coll_cleared", int'(collision), 0);
      if (i == GOF - 1) check("go_before_timeout", int'(game_state), 3);
      if (i == GOF) check("go_timeout", int'(game_state), 0);
    end

    // Wall hit at x=5.
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    pix(5, 200, 1'b1, 1'b0, 1'b0);
    fend();
    check("wall_coll", int'(collision), 1);
    check("wall_state", int'(game_state), 3);
    for (int i = 0; i < GOF; i++) fend();
    check("wall_timeout", int'(game_state), 0);

    // Reset in the middle of a frame with score 5.
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      pix(100 + k * 20, 240, 1'b1, 1'b0, 1'b1);
      fend();
    end
    check("pre_reset_score", int'(score), 5);
    pix(50, 50, 1'b1, 1'b0, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("async_reset_state", int'(game_state), 0);
    check("async_reset_coll", int'(collision), 0);
    check("async_reset_update", int'(update), 0);
    check("async_reset_score", int'(score), 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int f = 0; f < FPS + 1; f++) calm_frame();
    check("post_reset_update", int'(update), 0);
    check("post_reset_state", int'(game_state), 0);

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      for (int f = 0; f < int'($urandom_range(3, 1)); f++) begin
        rand_pixel();
        fend();
      end
      drive(1'b0, ($urandom % 2) == 0, HA, VA - 1, 1'b0, 1'b0, 1'b0, 1'b1);
      frames = 0;
      while (m_state != 0 && frames < 600) begin
        rand_frame();
        frames++;
      end
      check("random_game_bound", (frames < 600) ? 1 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Game-logic stage that closes the loop around the snake renderer.
- Consumes the per-pixel head/body/apple activity flags for each frame and detects apple, self and wall collisions.
- Runs the START/PLAY/GAME_OVER state machine and generates the movement `update` strobe.
- Its `collision`, `game_state` and `update` outputs feed the snake drawing block and the apple placement block directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BORDER, 10, wall thickness in pixels on every edge.
- BIT, 10, width of the pixel coordinates.
- FRAMES_PER_STEP, 8, frames between snake moves (>=1).
- GAME_OVER_FRAMES, 120, frames spent in GAME_OVER before returning to START.

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- x_pos  input  BIT  current pixel column
- y_pos  input  BIT  current pixel row
- video_active  input  1  high while (x_pos, y_pos) is inside the visible area
- frame_end  input  1  one-cycle pulse after the last visible pixel of a frame
- snake_head_active  input  1  head covers the current pixel
- snake_body_active  input  1  a body segment covers the current pixel
- apple_active  input  1  apple covers the current pixel
- start  input  1  synchronised, level start button
- game_state  output  2  START=00, PLAY=01, GAME_OVER=11
- collision  output  2  NONE=00, HIT=01, APPLE_COLLECTED=10
- update  output  1  one-cycle move strobe
- score  output  8  apples collected this game, saturating at 255

Behaviour:
- Reset values (asynchronous): game_state=START, collision=NONE, update=0, score=0. All per-frame flags and counters clear.
- Input alignment: the three *_active inputs are aligned to the same pixel. No internal delay is applied.
- Per-frame sticky flags, sampled only when video_active=1 and game_state=PLAY:
  - apple_f sets on head & apple.
  - self_f sets on head & body.
  - wall_f sets on head & (x_pos<BORDER | x_pos>=H_ACTIVE-BORDER | y_pos<BORDER | y_pos>=V_ACTIVE-BORDER).
- On frame_end, the flags resolve into the registered collision output, which then holds for one full frame until the next frame_end:
  - self_f|wall_f gives HIT. HIT wins over an apple in the same frame.
  - else apple_f gives APPLE_COLLECTED.
  - else NONE.
- Flag clearing:
  - All flags clear in the cycle after frame_end.
  - A pixel hit coinciding with frame_end is lost; this is acceptable, since frame_end falls outside the visible area.
- Score: increments by 1 on the frame_end that resolves to APPLE_COLLECTED, saturates at 255, and clears on the START->PLAY transition.
- FSM transitions, all registered and 1 cycle after the cause:
  - START: collision forced NONE. start=1 -> PLAY, and step_cnt clears.
  - PLAY: the frame_end resolving to HIT -> GAME_OVER, and go_cnt clears. Otherwise stay.
  - GAME_OVER: collision holds HIT until the first frame_end, then NONE. go_cnt counts frame_end pulses. On reaching GAME_OVER_FRAMES -> START.
  - start is ignored outside START.
  - reset in any state returns to START immediately.
- Update strobe:
  - step_cnt (width $clog2(FRAMES_PER_STEP)+1) counts frame_end pulses in PLAY only.
  - When step_cnt reaches FRAMES_PER_STEP-1 on a frame_end: update=1 for exactly the next cycle, and step_cnt wraps to 0.
  - No update is issued on the frame_end that causes the PLAY->GAME_OVER transition.
  - update is never high outside PLAY.
- Coordinate compares are unsigned on BIT-wide operands. The upper wall limits are parameter constants and are not computed at runtime.

Decomposition:
- Shared package (game_pkg) holds:
  - game state encodings START/PLAY/GAME_OVER;
  - collision encodings NONE/HIT/APPLE_COLLECTED;
  - direction encodings IDLE/UP/DOWN/LEFT/RIGHT, so the drawing and control blocks agree.
- One sub-module, frame_divider: counts frame_end pulses, is enabled by game_state==PLAY, and emits the update pulse. It is reused for the GAME_OVER timeout with a different terminal count.

Test Plan:
- Idle, then start: reset, then start=1 for one cycle -> game_state 00->01 one cycle later; score=0; first update pulse exactly FRAMES_PER_STEP=8 frame_end pulses later; update is 1 cycle wide.
- Apple: PLAY, head & apple overlap at pixel (100,100) -> on the next frame_end, collision=10 held for one frame, then 00; score=1.
- Self hit beats apple: head overlapping both apple and body in the same frame -> collision=01, game_state=11, score unchanged, no update pulse on that frame_end.
- Wall hit: head_active at x_pos=5 -> HIT at frame_end. Head at x_pos=10 (=BORDER) with no other overlap -> NONE.
- Timeout: in GAME_OVER, 120 frame_end pulses -> game_state=00 after the 120th. start=1 while in GAME_OVER has no effect.
- Reset mid-game: reset asserted asynchronously mid-frame in PLAY with score=5 -> outputs immediately 00/00/0/0; flags clear; no spurious update after release.
